// File: rtl/mp64_dma_arb.sv
// Byte-wide BRAM DMA port arbiter: round-robin over N masters, optional bounded
// priority for master 0, one outstanding transaction with a per-transaction timeout.
module mp64_dma_arb #(
  parameter int N_MST        = 3,
  parameter int PRIO0        = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MST-1:0]     m_req,
  input  logic [64*N_MST-1:0]  m_addr,
  input  logic [8*N_MST-1:0]   m_wdata,
  input  logic [N_MST-1:0]     m_wen,
  output logic [N_MST-1:0]     m_ack,
  output logic                 m_err,
  output logic [7:0]           m_rdata,
  output logic                 mem_req,
  output logic [63:0]          mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_wen,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ack,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 err_sticky,
  input  logic                 err_clr
);

  // state  | meaning
  // S_IDLE | no transaction; arbitrate among m_req each cycle
  // S_WAIT | mem_req held, timer running until mem_ack or expiry
  // S_RESP | one-cycle m_ack pulse to the granted master
  // S_GAP  | dead cycle so the served master can drop or re-raise m_req
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_GAP} state_t;

  localparam int             IW       = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam logic [15:0]    TMR_LOAD = 16'(TIMEOUT - 1);
  localparam logic [7:0]     SL       = 8'(STARVE_LIMIT);

  state_t           r_state;
  logic [IW-1:0]    r_rr;
  logic [7:0]       r_starve;
  logic [15:0]      r_tmr;
  logic [2:0]       r_gid;
  logic [N_MST-1:0] r_ack;
  logic             r_err;
  logic [7:0]       r_rdata;
  logic             r_mem_req;
  logic [63:0]      r_mem_addr;
  logic [7:0]       r_mem_wdata;
  logic             r_mem_wen;
  logic             r_err_sticky;

  logic             w_others;
  logic             w_found;
  logic [IW-1:0]    w_win;
  logic             w_expire;
  logic [N_MST-1:0] w_gid_oh;
  int               w_idx;

  assign w_others = |m_req[N_MST-1:1];
  assign w_expire = (r_state == S_WAIT) && !mem_ack && (r_tmr == 16'd0);
  assign w_gid_oh = N_MST'(1) << r_gid;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    if ((PRIO0 != 0) && m_req[0] && (!w_others || (r_starve < SL))) begin
      w_found = 1'b1;
    end else begin
      // Master 0 only joins the rotation when it has no priority of its own.
      for (int k = 0; k < N_MST; k++) begin
        w_idx = int'(r_rr) + k;
        if (w_idx >= N_MST) w_idx = w_idx - N_MST;
        if (!w_found && m_req[w_idx] && !((PRIO0 != 0) && (w_idx == 0))) begin
          w_found = 1'b1;
          w_win   = IW'(w_idx);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      r_starve    <= '0;
      r_tmr       <= '0;
      r_gid       <= '0;
      r_ack       <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wen   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= m_addr[64*int'(w_win) +: 64];
            r_mem_wdata <= m_wdata[8*int'(w_win) +: 8];
            r_mem_wen   <= m_wen[w_win];
            r_gid       <= 3'(w_win);
            r_tmr       <= TMR_LOAD;
            r_rr        <= (w_win == IW'(N_MST - 1)) ? '0 : w_win + 1'b1;
            if (w_win == '0 && w_others)
              r_starve <= (r_starve >= SL) ? SL : r_starve + 8'd1;
            else
              r_starve <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_rdata   <= mem_rdata;
            r_err     <= 1'b0;
            r_ack     <= w_gid_oh;
            r_state   <= S_RESP;
          end else if (r_tmr == 16'd0) begin
            r_mem_req <= 1'b0;
            r_rdata   <= 8'hFF;
            r_err     <= 1'b1;
            r_ack     <= w_gid_oh;
            r_state   <= S_RESP;
          end else begin
            r_tmr <= r_tmr - 16'd1;
          end
        end
        S_RESP: begin
          r_ack   <= '0;
          r_err   <= 1'b0;
          r_state <= S_GAP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_err_sticky <= 1'b0;
    else if (err_clr)  r_err_sticky <= 1'b0;
    else if (w_expire) r_err_sticky <= 1'b1;
  end

  assign m_ack      = r_ack;
  assign m_err      = r_err;
  assign m_rdata    = r_rdata;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wen    = r_mem_wen;
  assign busy       = (r_state != S_IDLE);
  assign grant_id   = r_gid;
  assign err_sticky = r_err_sticky;

endmodule
